// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit CLA reused over WIDTH/4 cycles with a registered carry chain.
// Optional overflow output enabled by defining CLA_SERIAL_OVF_EN.

module four_bit_CLA_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c0_i,
    output logic [3:0] sum_c,
    output logic       c4_c
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Flattened lookahead: every carry derived directly from g/p and c0
    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c[0] = c0_i;
        c[1] = g[0] | (p[0] & c0_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0_i);
        sum_c = p ^ c[3:0];
        c4_c  = c[4];
    end
endmodule

module cla_nibble_serial_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef CLA_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);
    localparam int unsigned NIB   = WIDTH / 4;
    localparam int unsigned IDX_W = $clog2(NIB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [3:0]       cla_sum;
    logic             cla_c4;

    four_bit_CLA_adder u_cla (
        .a_i   (a_q[4*idx_q +: 4]),
        .b_i   (b_q[4*idx_q +: 4]),
        .c0_i  (carry_q),
        .sum_c (cla_sum),
        .c4_c  (cla_c4)
    );

`ifdef CLA_SERIAL_OVF_EN
    logic ovf_q, ovf_d;
    logic last_nib;
    assign last_nib = (state_q == RUN) && (idx_q == IDX_W'(NIB - 1));

    // Sign overflow judged on the MSB nibble as it is written
    always_comb begin
        ovf_d = ovf_q;
        if (last_nib) begin
            ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cla_sum[3] != a_q[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else     ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Handshake flags are registered from the next state so they line up with it
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[4*idx_q +: 4] = cla_sum;
                carry_d             = cla_c4;
                if (idx_q == IDX_W'(NIB - 1)) begin
                    cout_d  = cla_c4;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN) || (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule
